cabac_bin_encoder: RTL and testbench

- Binary arithmetic encoder core, VVC-style; the encoder counterpart of the team's arithmetic Decoder.
- Consumes one bin per accepted cycle, in regular (context-coded) or bypass mode, and produces the byte stream the decoder's byte fetcher reads.
- Handles range/low update, renormalisation, carry propagation over outstanding 0xFF bytes, and end-of-slice flush.
- Produces golden bitstreams for decoder benches and is the base of the future encoder datapath.

---
 rtl/cabac_bin_encoder.sv | 245 ++++++++++++++++++++++++
 tb/tb_cabac_bin_encoder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cabac_bin_encoder.sv
// cabac_bin_encoder: VVC-style binary arithmetic encoder core.
// Takes one regular or bypass bin per accepted cycle, keeps range/low,
// resolves carries over outstanding 0xFF bytes and streams bytes out.
// Valid/ready: a bin moves when bin_valid && bin_ready, a byte moves when
// byte_valid && byte_ready; byte_out is held while byte_valid && !byte_ready.
module cabac_bin_encoder #(
   parameter int OUTSTANDING_W = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       bin_valid,
   output logic       bin_ready,
   input  logic       bin,
   input  logic       bypass,
   input  logic [7:0] pState_in,
   input  logic       flush,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic       done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EMIT  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [OUTSTANDING_W-1:0] NUM_ONE = {{(OUTSTANDING_W-1){1'b0}}, 1'b1};

   state_t                   state_q;
   logic                     flushing_q;
   logic [8:0]               range_q;
   logic [31:0]              low_q;
   logic [5:0]               bits_left_q;   // always positive in practice (6..23)
   logic [7:0]               buf_byte_q;
   logic [OUTSTANDING_W-1:0] num_buf_q;
   // Pending bytes after the one on byte_out: cnt copies of rep, then tail bytes.
   logic [OUTSTANDING_W-1:0] q_cnt_q;
   logic [7:0]               q_rep_q;
   logic [15:0]              q_tail_q;
   logic [1:0]               q_tail_n_q;

   logic unused_pstate_bits;
   assign unused_pstate_bits = ^pState_in[1:0];

   // Range/low update for the bin on the input, before WriteOut.
   logic [8:0]  prod, r_lps, r_mps, b_range;
   logic [2:0]  lps_shift;
   logic [31:0] b_low;
   logic [5:0]  b_bits;
   always_comb begin
      prod  = {4'd0, pState_in[6:2]} * {5'd0, range_q[8:5]};
      r_lps = (prod >> 1) + 9'd4;
      r_mps = range_q - r_lps;
      if      (r_lps[7]) lps_shift = 3'd1;
      else if (r_lps[6]) lps_shift = 3'd2;
      else if (r_lps[5]) lps_shift = 3'd3;
      else if (r_lps[4]) lps_shift = 3'd4;
      else if (r_lps[3]) lps_shift = 3'd5;
      else               lps_shift = 3'd6;
      b_range = range_q;
      b_low   = low_q;
      b_bits  = bits_left_q;
      if (bypass) begin
         b_low  = {low_q[30:0], 1'b0} + (bin ? {23'd0, range_q} : 32'd0);
         b_bits = bits_left_q - 6'd1;
      end else if (bin == pState_in[7]) begin
         if (r_mps[8]) begin
            b_range = r_mps;
         end else begin
            b_low   = {low_q[30:0], 1'b0};
            b_range = {r_mps[7:0], 1'b0};
            b_bits  = bits_left_q - 6'd1;
         end
      end else begin
         b_low   = (low_q + {23'd0, r_mps}) << lps_shift;
         b_range = r_lps << lps_shift;
         b_bits  = bits_left_q - {3'd0, lps_shift};
      end
   end

   // WriteOut: pull the lead byte once fewer than 12 bits are left.
   logic [5:0]               lead_shift, nx_bits;
   logic [8:0]               lead;
   logic [31:0]              nx_low;
   logic [7:0]               nx_buf, wo_first, wo_rep;
   logic [OUTSTANDING_W-1:0] nx_num;
   logic                     wo_first_v;
   always_comb begin
      lead_shift = 6'd24 - b_bits;
      lead       = 9'(b_low >> lead_shift);
      nx_low     = b_low;
      nx_bits    = b_bits;
      nx_buf     = buf_byte_q;
      nx_num     = num_buf_q;
      wo_first_v = 1'b0;
      wo_first   = buf_byte_q + {7'd0, lead[8]};
      wo_rep     = 8'hFF + {7'd0, lead[8]};
      if (b_bits < 6'd12) begin
         nx_bits = b_bits + 6'd8;
         nx_low  = b_low & (32'hFFFF_FFFF >> nx_bits);
         if (lead == 9'h0FF) begin
            nx_num = num_buf_q + NUM_ONE;
         end else begin
            wo_first_v = (num_buf_q != '0);
            nx_buf     = lead[7:0];
            nx_num     = NUM_ONE;
         end
      end
   end

   // Flush: carry out of low and the left-aligned tail bits of low>>8.
   logic [5:0]  fl_shift, fl_nbits;
   logic        fl_carry;
   logic [31:0] fl_low;
   logic [15:0] fl_tail;
   always_comb begin
      fl_shift = 6'd32 - bits_left_q;
      fl_carry = (low_q >> fl_shift) != 32'd0;
      fl_low   = fl_carry ? (low_q - (32'd1 << fl_shift)) : low_q;
      fl_nbits = 6'd24 - bits_left_q;
      fl_tail  = 16'((fl_low >> 8) << (6'd16 - fl_nbits));
   end

   // Select the byte source for this state and split it into head byte + rest.
   logic                     s_first_v, head_v;
   logic [7:0]               s_first, s_rep, head;
   logic [OUTSTANDING_W-1:0] s_cnt, rest_cnt;
   logic [1:0]               s_tail_n, rest_tail_n;
   logic [15:0]              s_tail, rest_tail;
   always_comb begin
      s_first_v = 1'b0;
      s_first   = wo_first;
      s_rep     = wo_rep;
      s_cnt     = '0;
      s_tail_n  = 2'd0;
      s_tail    = 16'd0;
      case (state_q)
         ST_EMIT: begin
            s_rep    = q_rep_q;
            s_cnt    = q_cnt_q;
            s_tail_n = q_tail_n_q;
            s_tail   = q_tail_q;
         end
         ST_FLUSH: begin
            s_first_v = (num_buf_q != '0);
            s_first   = buf_byte_q + {7'd0, fl_carry};
            s_rep     = fl_carry ? 8'h00 : 8'hFF;
            s_cnt     = (num_buf_q != '0) ? (num_buf_q - NUM_ONE) : '0;
            s_tail_n  = (fl_nbits > 6'd8) ? 2'd2 : 2'd1;
            s_tail    = fl_tail;
         end
         default: begin
            s_first_v = wo_first_v;
            s_cnt     = wo_first_v ? (num_buf_q - NUM_ONE) : '0;
         end
      endcase
      head_v      = s_first_v || (s_cnt != '0) || (s_tail_n != 2'd0);
      head        = s_tail[15:8];
      rest_cnt    = s_cnt;
      rest_tail_n = s_tail_n;
      rest_tail   = s_tail;
      if (s_first_v) begin
         head = s_first;
      end else if (s_cnt != '0) begin
         head     = s_rep;
         rest_cnt = s_cnt - NUM_ONE;
      end else if (s_tail_n != 2'd0) begin
         rest_tail   = {s_tail[7:0], 8'h00};
         rest_tail_n = s_tail_n - 2'd1;
      end
   end

   // Encoder state, byte queue and FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         flushing_q  <= 1'b0;
         range_q     <= 9'd510;
         low_q       <= 32'd0;
         bits_left_q <= 6'd23;
         buf_byte_q  <= 8'hFF;
         num_buf_q   <= '0;
         q_cnt_q     <= '0;
         q_rep_q     <= 8'h00;
         q_tail_q    <= 16'd0;
         q_tail_n_q  <= 2'd0;
         byte_out    <= 8'h00;
         byte_valid  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bin_valid) begin
                  range_q     <= b_range;
                  low_q       <= nx_low;
                  bits_left_q <= nx_bits;
                  buf_byte_q  <= nx_buf;
                  num_buf_q   <= nx_num;
                  if (head_v) begin
                     byte_out   <= head;
                     byte_valid <= 1'b1;
                     q_cnt_q    <= rest_cnt;
                     q_rep_q    <= s_rep;
                     q_tail_q   <= rest_tail;
                     q_tail_n_q <= rest_tail_n;
                     state_q    <= ST_EMIT;
                  end
               end else if (flush) begin
                  state_q <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               byte_out   <= head;
               byte_valid <= 1'b1;
               q_cnt_q    <= rest_cnt;
               q_rep_q    <= s_rep;
               q_tail_q   <= rest_tail;
               q_tail_n_q <= rest_tail_n;
               flushing_q <= 1'b1;
               state_q    <= ST_EMIT;
            end
            ST_EMIT: begin
               if (byte_ready) begin
                  if (head_v) begin
                     byte_out   <= head;
                     q_cnt_q    <= rest_cnt;
                     q_tail_q   <= rest_tail;
                     q_tail_n_q <= rest_tail_n;
                  end else begin
                     byte_valid <= 1'b0;
                     state_q    <= flushing_q ? ST_DONE : ST_IDLE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bin_ready = (state_q == ST_IDLE);
   assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_cabac_bin_encoder.sv
// Directed bench for cabac_bin_encoder with hand-computed expectations.
module tb_cabac_bin_encoder;

   logic       clk;
   logic       reset;
   logic       bin_valid;
   logic       bin_ready;
   logic       bin;
   logic       bypass;
   logic [7:0] pState_in;
   logic       flush;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       byte_ready;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];

   cabac_bin_encoder #(.OUTSTANDING_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .bin_valid  (bin_valid),
      .bin_ready  (bin_ready),
      .bin        (bin),
      .bypass     (bypass),
      .pState_in  (pState_in),
      .flush      (flush),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .done       (done)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no end of test, expected finish before 500000");
      $fatal(1, "watchdog expired");
   end

   // Byte capture: record every handshake, sampled between clock edges
   always begin
      @(negedge clk);
      #1;
      if (byte_valid && byte_ready) got_q.push_back(byte_out);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_bytes(input string tag);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (i < got_q.size()) check($sformatf("%s_byte%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
   endtask

   task automatic do_reset();
      bin_valid = 1'b0;
      flush     = 1'b0;
      reset     = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      got_q.delete();
      exp_q.delete();
   endtask

   // Present one bin, wait (bounded) for bin_ready, return after acceptance
   task automatic send_bin(input logic b, input logic byp, input logic [7:0] ps);
      int guard;
      guard = 0;
      while (!bin_ready && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      check("bin_ready_wait", {31'd0, guard < 40}, 32'd1);
      bin_valid = 1'b1;
      bin       = b;
      bypass    = byp;
      pState_in = ps;
      @(negedge clk);
      bin_valid = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int guard;
      guard = 0;
      while (!done && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      check({tag, "_timeout"}, {31'd0, guard < 40}, 32'd1);
   endtask

   task automatic wait_ready(input string tag);
      int guard;
      guard = 0;
      while (!bin_ready && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      check({tag, "_timeout"}, {31'd0, guard < 40}, 32'd1);
   endtask

   logic [35:0] carry_seq;

   initial begin
      reset      = 1'b1;
      bin_valid  = 1'b0;
      bin        = 1'b0;
      bypass     = 1'b0;
      pState_in  = 8'h00;
      flush      = 1'b0;
      byte_ready = 1'b1;

      // Reset state
      do_reset();
      check("rst_bin_ready", {31'd0, bin_ready}, 32'd1);
      check("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
      check("rst_byte_out", {24'd0, byte_out}, 32'h00);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_range", {23'd0, dut.range_q}, 32'd510);
      check("rst_low", dut.low_q, 32'd0);
      check("rst_bits_left", {26'd0, dut.bits_left_q}, 32'd23);
      check("rst_buf_byte", {24'd0, dut.buf_byte_q}, 32'hFF);
      check("rst_num_buf", {16'd0, dut.num_buf_q}, 32'd0);

      // Bypass bin 1 from reset
      send_bin(1'b1, 1'b1, 8'h00);
      check("byp1_range", {23'd0, dut.range_q}, 32'd510);
      check("byp1_low", dut.low_q, 32'd510);
      check("byp1_bits", {26'd0, dut.bits_left_q}, 32'd22);
      check("byp1_no_byte", {31'd0, byte_valid}, 32'd0);

      // Regular LPS, p=31: rLPS=236, n=1
      do_reset();
      send_bin(1'b1, 1'b0, 8'h7C);
      check("lps31_low", dut.low_q, 32'd548);
      check("lps31_range", {23'd0, dut.range_q}, 32'd472);
      check("lps31_bits", {26'd0, dut.bits_left_q}, 32'd22);

      // Regular MPS, p=0: range 506, no renormalisation
      do_reset();
      send_bin(1'b0, 1'b0, 8'h00);
      check("mps0_range", {23'd0, dut.range_q}, 32'd506);
      check("mps0_low", dut.low_q, 32'd0);
      check("mps0_bits", {26'd0, dut.bits_left_q}, 32'd23);

      // Regular LPS, p=0: rLPS=4, n=6 -> low=506<<6, range=256
      do_reset();
      send_bin(1'b1, 1'b0, 8'h00);
      check("lps0_low", dut.low_q, 32'd32384);
      check("lps0_range", {23'd0, dut.range_q}, 32'd256);
      check("lps0_bits", {26'd0, dut.bits_left_q}, 32'd17);

      // Two MPS bins p=31: 510->274, then 274-128=146 renormalised to 292
      do_reset();
      send_bin(1'b0, 1'b0, 8'h7C);
      check("mps31a_range", {23'd0, dut.range_q}, 32'd274);
      send_bin(1'b0, 1'b0, 8'h7C);
      check("mps31b_range", {23'd0, dut.range_q}, 32'd292);
      check("mps31b_bits", {26'd0, dut.bits_left_q}, 32'd22);

      // 20 bypass zeros: one 0x00 byte after bin 20
      do_reset();
      for (int i = 0; i < 19; i++) send_bin(1'b0, 1'b1, 8'h00);
      check("z19_no_byte", {31'd0, byte_valid}, 32'd0);
      send_bin(1'b0, 1'b1, 8'h00);
      check("z20_bin_ready", {31'd0, bin_ready}, 32'd0);
      check("z20_byte_valid", {31'd0, byte_valid}, 32'd1);
      check("z20_byte_out", {24'd0, byte_out}, 32'h00);
      @(negedge clk);
      check("z20_back_idle", {31'd0, bin_ready}, 32'd1);
      check("z20_valid_drop", {31'd0, byte_valid}, 32'd0);
      #2;
      exp_q.push_back(8'h00);
      check_bytes("z20");

      // Same stream with backpressure; a flush during EMIT is ignored
      do_reset();
      byte_ready = 1'b0;
      for (int i = 0; i < 20; i++) send_bin(1'b0, 1'b1, 8'h00);
      check("bp_valid", {31'd0, byte_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         flush = (i == 1);
         @(negedge clk);
         check("bp_hold_byte", {24'd0, byte_out}, 32'h00);
         check("bp_hold_ready", {31'd0, bin_ready}, 32'd0);
         check("bp_hold_valid", {31'd0, byte_valid}, 32'd1);
      end
      flush = 1'b0;
      byte_ready = 1'b1;
      @(negedge clk);
      check("bp_release_valid", {31'd0, byte_valid}, 32'd0);
      check("bp_release_ready", {31'd0, bin_ready}, 32'd1);
      #2;
      exp_q.push_back(8'h00);
      check_bytes("bp");
      @(negedge clk);
      check("bp_flush_ignored_ready", {31'd0, bin_ready}, 32'd1);
      check("bp_flush_ignored_done", {31'd0, done}, 32'd0);

      // Carry over outstanding bytes: 0x7F,0xFF,0xFF then a lead of 0x100
      do_reset();
      carry_seq = 36'b1000_0000_1000_0000_1000_0000_1000_0000_1001;
      for (int i = 0; i < 35; i++) send_bin(carry_seq[35-i], 1'b1, 8'h00);
      check("carry_buf_byte", {24'd0, dut.buf_byte_q}, 32'h7F);
      check("carry_num_buf", {16'd0, dut.num_buf_q}, 32'd3);
      check("carry_pre_none", got_q.size(), 32'd0);
      send_bin(carry_seq[0], 1'b1, 8'h00);
      check("carry_emit_ready", {31'd0, bin_ready}, 32'd0);
      check("carry_first_byte", {24'd0, byte_out}, 32'h80);
      wait_ready("carry_drain");
      #2;
      exp_q.push_back(8'h80);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      check_bytes("carry");
      check("carry_low", dut.low_q, 32'd494);
      check("carry_bits", {26'd0, dut.bits_left_q}, 32'd19);
      check("carry_new_buf", {24'd0, dut.buf_byte_q}, 32'h00);
      check("carry_new_num", {16'd0, dut.num_buf_q}, 32'd1);

      // Flush after the carry stream: buffered 0x00, then 5 tail bits 00001 -> 0x08
      pulse_flush();
      wait_done("carry_flush");
      #2;
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h08);
      check_bytes("carry_flush");
      check("carry_done_ready", {31'd0, bin_ready}, 32'd0);
      check("carry_done_valid", {31'd0, byte_valid}, 32'd0);
      repeat (4) @(negedge clk);
      #2;
      check("carry_no_more_bytes", got_q.size(), 32'd5);
      check("carry_done_held", {31'd0, done}, 32'd1);

      // Flush straight from reset: nothing buffered, one tail byte 0x00
      do_reset();
      pulse_flush();
      wait_done("empty_flush");
      #2;
      exp_q.push_back(8'h00);
      check_bytes("empty_flush");

      // Reset while a byte is pending: byte_valid drops at once and the byte is lost
      do_reset();
      byte_ready = 1'b0;
      for (int i = 0; i < 20; i++) send_bin(1'b0, 1'b1, 8'h00);
      check("mid_valid_before", {31'd0, byte_valid}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("mid_valid_async", {31'd0, byte_valid}, 32'd0);
      check("mid_ready_async", {31'd0, bin_ready}, 32'd1);
      check("mid_range_async", {23'd0, dut.range_q}, 32'd510);
      @(negedge clk);
      reset = 1'b0;
      byte_ready = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      check("mid_dropped", got_q.size(), 32'd0);
      check("mid_valid_after", {31'd0, byte_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
